// File: rtl/alive_mon_pkg.sv
// Shared types and defaults for the multi-channel ALIVE heartbeat monitor.
// Optional build macro handled by the channel: ALIVE_MON_SYNC_EN.
package alive_mon_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'b001,
        ST_ACQ  = 3'b010,
        ST_ACT  = 3'b100
    } alive_state_t;

    localparam int DEF_TIMEOUT   = 2000;
    localparam int DEF_ACQ_EDGES = 2;
    localparam int EDGE_CNT_W    = 4;

endpackage

// File: rtl/alive_mon_ch.sv
// One heartbeat channel: optional 2-flop synchroniser, edge detect, IDLE/ACQUIRE/ACTIVE FSM,
// timeout counter and sticky LOST flag. Macro ALIVE_MON_SYNC_EN enables the synchroniser.
module alive_mon_ch
    import alive_mon_pkg::*;
#(
    parameter int CNT_W     = 12,
    parameter int TIMEOUT   = DEF_TIMEOUT,
    parameter int ACQ_EDGES = DEF_ACQ_EDGES
) (
    input  logic         CLK,
    input  logic         RESET_N,
    input  logic         alive,
    input  logic         enable,
    input  logic         clear,
    output logic         alive_status,
    output logic         loss_pulse,
    output logic         lost,
    output alive_state_t state_dbg
);

    localparam logic [CNT_W-1:0]      TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [EDGE_CNT_W-1:0] ACQ_C     = EDGE_CNT_W'(ACQ_EDGES);

    alive_state_t           state;
    logic [CNT_W-1:0]       counter;
    logic [EDGE_CNT_W-1:0]  edge_cnt;
    logic                   stored;
    logic                   sample;
    logic                   edge_det;

`ifdef ALIVE_MON_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], alive};
        end
    end

    assign sample = sync_q[1];
`else
    assign sample = alive;
`endif

    assign edge_det     = sample ^ stored;
    assign alive_status = (state == ST_ACT);
    assign state_dbg    = state;

    // A timeout and a CLEAR in the same cycle: the later LOST set overrides the clear.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state      <= ST_IDLE;
            counter    <= '0;
            edge_cnt   <= '0;
            stored     <= 1'b0;
            loss_pulse <= 1'b0;
            lost       <= 1'b0;
        end else begin
            stored     <= sample;
            loss_pulse <= 1'b0;
            if (clear) begin
                lost <= 1'b0;
            end
            if (!enable) begin
                state    <= ST_IDLE;
                counter  <= '0;
                edge_cnt <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        counter <= '0;
                        if (edge_det) begin
                            state    <= ST_ACQ;
                            edge_cnt <= EDGE_CNT_W'(1);
                        end
                    end
                    ST_ACQ: begin
                        if (edge_det) begin
                            counter  <= '0;
                            edge_cnt <= edge_cnt + EDGE_CNT_W'(1);
                            if (edge_cnt + EDGE_CNT_W'(1) == ACQ_C) begin
                                state <= ST_ACT;
                            end
                        end else if (counter == TIMEOUT_C) begin
                            state    <= ST_IDLE;
                            counter  <= '0;
                            edge_cnt <= '0;
                        end else begin
                            counter <= counter + CNT_W'(1);
                        end
                    end
                    ST_ACT: begin
                        if (edge_det) begin
                            counter <= '0;
                        end else if (counter == TIMEOUT_C) begin
                            state      <= ST_IDLE;
                            counter    <= '0;
                            edge_cnt   <= '0;
                            loss_pulse <= 1'b1;
                            lost       <= 1'b1;
                        end else begin
                            counter <= counter + CNT_W'(1);
                        end
                    end
                    default: begin
                        state    <= ST_IDLE;
                        counter  <= '0;
                        edge_cnt <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/alive_monitor_mc.sv
// Multi-channel ALIVE monitor top: NUM_CH independent channels plus a registered ANY_LOST.
// Build macro ALIVE_MON_SYNC_EN adds a 2-flop synchroniser per ALIVE input (+2 clk latency).
module alive_monitor_mc
    import alive_mon_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int CNT_W     = 12,
    parameter int TIMEOUT   = DEF_TIMEOUT,
    parameter int ACQ_EDGES = DEF_ACQ_EDGES
) (
    input  logic                CLK,
    input  logic                RESET_N,
    input  logic [NUM_CH-1:0]   ALIVE,
    input  logic [NUM_CH-1:0]   ENABLE,
    input  logic [NUM_CH-1:0]   CLEAR,
    output logic [NUM_CH-1:0]   ALIVE_STATUS,
    output logic [NUM_CH-1:0]   LOSS_PULSE,
    output logic [NUM_CH-1:0]   LOST,
    output logic                ANY_LOST,
    output logic [3*NUM_CH-1:0] STATE_DBG
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        alive_mon_ch #(
            .CNT_W     (CNT_W),
            .TIMEOUT   (TIMEOUT),
            .ACQ_EDGES (ACQ_EDGES)
        ) u_ch (
            .CLK          (CLK),
            .RESET_N      (RESET_N),
            .alive        (ALIVE[i]),
            .enable       (ENABLE[i]),
            .clear        (CLEAR[i]),
            .alive_status (ALIVE_STATUS[i]),
            .loss_pulse   (LOSS_PULSE[i]),
            .lost         (LOST[i]),
            .state_dbg    (STATE_DBG[3*i +: 3])
        );
    end

    // Registered so ANY_LOST trails LOST by exactly one clock.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            ANY_LOST <= 1'b0;
        end else begin
            ANY_LOST <= |LOST;
        end
    end

endmodule

// File: tb/tb_alive_monitor_mc.sv
// Bench for alive_monitor_mc: 4 channels, TIMEOUT=20, ACQ_EDGES=3; segment table plus directed
// corner sequences, with a per-cycle expected-output queue. Latencies shift by 2 under ALIVE_MON_SYNC_EN.
module tb_alive_monitor_mc;

    localparam int T   = 20;
    localparam int ACQ = 3;
`ifdef ALIVE_MON_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic        CLK = 1'b0;
    logic        RESET_N = 1'b1;
    logic [3:0]  ALIVE = '0;
    logic [3:0]  ENABLE = '1;
    logic [3:0]  CLEAR = '0;
    logic [3:0]  ALIVE_STATUS;
    logic [3:0]  LOSS_PULSE;
    logic [3:0]  LOST;
    logic        ANY_LOST;
    logic [11:0] STATE_DBG;

    alive_monitor_mc #(
        .NUM_CH    (4),
        .CNT_W     (12),
        .TIMEOUT   (T),
        .ACQ_EDGES (ACQ)
    ) dut (
        .CLK          (CLK),
        .RESET_N      (RESET_N),
        .ALIVE        (ALIVE),
        .ENABLE       (ENABLE),
        .CLEAR        (CLEAR),
        .ALIVE_STATUS (ALIVE_STATUS),
        .LOSS_PULSE   (LOSS_PULSE),
        .LOST         (LOST),
        .ANY_LOST     (ANY_LOST),
        .STATE_DBG    (STATE_DBG)
    );

    // ---------------- clock / watchdog ----------------
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int          n_pass = 0;
    int          n_chk  = 0;
    logic [12:0] exp_q[$];
    logic [3:0]  a_cur  = '0;
    logic [3:0]  en_cur = '1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    // Spec-level reference: state 0=IDLE 1=ACQUIRE 2=ACTIVE.
    int         m_st[4];
    int         m_cnt[4];
    int         m_ec[4];
    logic       m_stored[4];
    logic       m_s1[4];
    logic       m_s2[4];
    logic [3:0] m_lost;
    logic [3:0] m_pulse;
    logic       m_any;

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_st[i] = 0; m_cnt[i] = 0; m_ec[i] = 0;
            m_stored[i] = 1'b0; m_s1[i] = 1'b0; m_s2[i] = 1'b0;
        end
        m_lost = '0; m_pulse = '0; m_any = 1'b0;
    endtask

    task automatic model_step(input logic [3:0] a, input logic [3:0] en, input logic [3:0] clr);
        logic s, e;
        m_any   = |m_lost;
        m_pulse = '0;
        for (int i = 0; i < 4; i++) begin
            s = (LAT != 0) ? m_s2[i] : a[i];
            e = (s != m_stored[i]);
            if (clr[i]) m_lost[i] = 1'b0;
            if (!en[i]) begin
                m_st[i] = 0; m_cnt[i] = 0; m_ec[i] = 0;
            end else if (m_st[i] == 0) begin
                m_cnt[i] = 0;
                if (e) begin m_st[i] = 1; m_ec[i] = 1; end
            end else if (e) begin
                m_cnt[i] = 0;
                if (m_st[i] == 1) begin
                    m_ec[i] = m_ec[i] + 1;
                    if (m_ec[i] == ACQ) m_st[i] = 2;
                end
            end else if (m_cnt[i] == T) begin
                if (m_st[i] == 2) begin m_pulse[i] = 1'b1; m_lost[i] = 1'b1; end
                m_st[i] = 0; m_cnt[i] = 0; m_ec[i] = 0;
            end else begin
                m_cnt[i] = m_cnt[i] + 1;
            end
            m_stored[i] = s;
            m_s2[i] = m_s1[i];
            m_s1[i] = a[i];
        end
    endtask

    function automatic logic [12:0] model_out();
        logic [3:0] st;
        for (int i = 0; i < 4; i++) st[i] = (m_st[i] == 2);
        return {st, m_pulse, m_lost, m_any};
    endfunction

    // ---------------- driver ----------------
    task automatic cyc(input logic [3:0] a, input logic [3:0] en, input logic [3:0] clr);
        logic [12:0] exp;
        ALIVE = a; ENABLE = en; CLEAR = clr;
        model_step(a, en, clr);
        exp_q.push_back(model_out());
        @(posedge CLK);
        #1;
        exp = exp_q.pop_front();
        check("sb_outputs", {ALIVE_STATUS, LOSS_PULSE, LOST, ANY_LOST}, exp);
    endtask

    // ---------------- segment table ----------------
    typedef struct {
        logic [3:0]  tog;
        int          reps;
        logic [3:0]  st;
        logic [3:0]  lost;
        logic        any;
        logic [11:0] dbg;
    } seg_t;

    seg_t tbl1[$];
    seg_t tbl2[$];

    task automatic run_seg(input seg_t s, input string tag);
        a_cur = a_cur ^ s.tog;
        cyc(a_cur, en_cur, 4'b0000);
        for (int r = 1; r < s.reps; r++) cyc(a_cur, en_cur, 4'b0000);
        check({tag, "_out"}, {ALIVE_STATUS, LOSS_PULSE, LOST, ANY_LOST}, {s.st, 4'b0000, s.lost, s.any});
        check({tag, "_state"}, STATE_DBG, s.dbg);
    endtask

    logic st_h[41];
    logic pu_h[41];
    logic lo_h[41];
    logic an_h[41];

    initial begin
        int rise_at, fall_at, idx, pcount, cl_at;

        for (int k = 0; k < 20; k++)
            tbl1.push_back('{4'b0001, 10, 4'b0001, 4'b0000, 1'b0, {3'b001, 3'b001, 3'b001, 3'b100}});
        tbl2.push_back('{4'b0010, 5,  4'b0000, 4'b0001, 1'b1, {3'b001, 3'b001, 3'b010, 3'b001}});
        tbl2.push_back('{4'b0010, 10, 4'b0000, 4'b0001, 1'b1, {3'b001, 3'b001, 3'b010, 3'b001}});
        tbl2.push_back('{4'b0000, 20, 4'b0000, 4'b0001, 1'b1, {3'b001, 3'b001, 3'b001, 3'b001}});
        tbl2.push_back('{4'b0100, 5,  4'b0000, 4'b0001, 1'b1, {3'b001, 3'b010, 3'b001, 3'b001}});
        tbl2.push_back('{4'b0100, 5,  4'b0000, 4'b0001, 1'b1, {3'b001, 3'b010, 3'b001, 3'b001}});
        tbl2.push_back('{4'b0100, 5,  4'b0100, 4'b0001, 1'b1, {3'b001, 3'b100, 3'b001, 3'b001}});

        // Reset
        #2 RESET_N = 1'b0;
        #1;
        check("reset_outputs", {ALIVE_STATUS, LOSS_PULSE, LOST, ANY_LOST}, 13'd0);
        check("reset_state", STATE_DBG, {4{3'b001}});
        model_reset();
        repeat (3) @(posedge CLK);
        #1 RESET_N = 1'b1;

        // Rise on the 3rd edge of ch0, toggling every 10 clk
        rise_at = -1;
        for (int k = 0; k < 30; k++) begin
            if (k % 10 == 0) a_cur[0] = ~a_cur[0];
            cyc(a_cur, en_cur, 4'b0000);
            if (rise_at < 0 && ALIVE_STATUS[0]) rise_at = k;
        end
        check("rise_latency", rise_at, 20 + LAT);
        check("others_idle", ALIVE_STATUS[3:1], 3'b000);

        // 200 clk of steady toggling
        foreach (tbl1[i]) run_seg(tbl1[i], $sformatf("tbl1_%0d", i));

        // Last edge then silence: fall, pulse, LOST, ANY_LOST lag
        a_cur[0] = ~a_cur[0];
        cyc(a_cur, en_cur, 4'b0000);
        fall_at = -1;
        pcount  = 0;
        for (int n = 1; n <= 40; n++) begin
            cyc(a_cur, en_cur, 4'b0000);
            st_h[n] = ALIVE_STATUS[0]; pu_h[n] = LOSS_PULSE[0];
            lo_h[n] = LOST[0];         an_h[n] = ANY_LOST;
            if (LOSS_PULSE[0]) pcount++;
            if (fall_at < 0 && !ALIVE_STATUS[0]) fall_at = n;
        end
        idx = (fall_at > 0 && fall_at < 40) ? fall_at : 1;
        check("fall_latency", fall_at, T + 1 + LAT);
        check("loss_pulse_at_fall", pu_h[idx], 1'b1);
        check("loss_pulse_next", pu_h[idx+1], 1'b0);
        check("lost_at_fall", lo_h[idx], 1'b1);
        check("any_lost_at_fall", an_h[idx], 1'b0);
        check("any_lost_next", an_h[idx+1], 1'b1);
        check("loss_pulse_count", pcount, 1);

        // ch1 silent acquisition failure, then ch2 to ACTIVE
        foreach (tbl2[i]) run_seg(tbl2[i], $sformatf("tbl2_%0d", i));

        // Edge in the same cycle as counter==TIMEOUT on ch2
        a_cur[2] = ~a_cur[2];
        cyc(a_cur, en_cur, 4'b0000);
        for (int j = 1; j <= T; j++) cyc(a_cur, en_cur, 4'b0000);
        check("pre_boundary_active", ALIVE_STATUS[2], 1'b1);
        a_cur[2] = ~a_cur[2];
        cyc(a_cur, en_cur, 4'b0000);
        check("edge_beats_timeout", {ALIVE_STATUS[2], LOSS_PULSE[2], LOST[2]}, 3'b100);
        repeat (10) cyc(a_cur, en_cur, 4'b0000);
        check("still_active", ALIVE_STATUS[2], 1'b1);

        // Disable ch2, then re-enable restarts from IDLE
        en_cur = 4'b1011;
        cyc(a_cur, en_cur, 4'b0000);
        check("disable_drop", {ALIVE_STATUS[2], LOSS_PULSE[2], LOST[2]}, 3'b000);
        check("disable_idle", STATE_DBG[8:6], 3'b001);
        en_cur = 4'b1111;
        repeat (3) cyc(a_cur, en_cur, 4'b0000);
        check("reenable_idle", STATE_DBG[8:6], 3'b001);
        a_cur[2] = ~a_cur[2];
        repeat (3) cyc(a_cur, en_cur, 4'b0000);
        check("reenable_acquire", {STATE_DBG[8:6], ALIVE_STATUS[2]}, {3'b010, 1'b0});

        // Lone CLEAR, then CLEAR colliding with a new loss, then lone CLEAR
        cyc(a_cur, en_cur, 4'b0001);
        check("clear_lone", {LOST[0], ANY_LOST}, 2'b01);
        cyc(a_cur, en_cur, 4'b0000);
        check("any_after_clear", ANY_LOST, 1'b0);
        cl_at = 10 + T + 1 + LAT;
        for (int n = 0; n <= cl_at + 2; n++) begin
            if (n == 0 || n == 5 || n == 10) a_cur[0] = ~a_cur[0];
            cyc(a_cur, en_cur, (n == cl_at) ? 4'b0001 : 4'b0000);
            if (n == cl_at) check("collide_set_wins", {LOSS_PULSE[0], LOST[0]}, 2'b11);
        end
        cyc(a_cur, en_cur, 4'b0001);
        check("clear_after_loss", {LOST[0], ANY_LOST}, 2'b01);
        cyc(a_cur, en_cur, 4'b0000);
        check("any_clear_lag", ANY_LOST, 1'b0);

        // All channels ACTIVE, then asynchronous reset with no clock edge
        for (int n = 0; n < 15; n++) begin
            if (n == 0 || n == 5 || n == 10) a_cur = ~a_cur;
            cyc(a_cur, en_cur, 4'b0000);
        end
        check("all_active", ALIVE_STATUS, 4'b1111);
        #2 RESET_N = 1'b0;
        #1;
        check("async_reset_out", {ALIVE_STATUS, LOSS_PULSE, LOST, ANY_LOST}, 13'd0);
        check("async_reset_state", STATE_DBG, {4{3'b001}});
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        check("reset_hold", {ALIVE_STATUS, LOSS_PULSE, LOST, ANY_LOST}, 13'd0);
        RESET_N = 1'b1;

        // High ALIVE after reset: spurious edge enters ACQUIRE only and times out silently
        repeat (3) cyc(a_cur, en_cur, 4'b0000);
        check("spurious_acquire", STATE_DBG[11:9], {2'b00, ~a_cur[3], a_cur[3]} << 0 == 4'b0 ? 3'b001 : (a_cur[3] ? 3'b010 : 3'b001));
        repeat (30) cyc(a_cur, en_cur, 4'b0000);
        check("spurious_silent", {ALIVE_STATUS, LOSS_PULSE, LOST, ANY_LOST}, 13'd0);
        check("spurious_idle", STATE_DBG, {4{3'b001}});

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
